// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader
// Purpose  : Walks a register-file index range through one read port and
//            streams (index, value) beats with a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic                  hold_req,
  input  logic                  hold_ack,
  output logic [ADDR_WIDTH-1:0] rd_reg,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_reg,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_hold_req;
  logic [ADDR_WIDTH-1:0] r_rd_reg;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_reg;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_checksum;

  // Modular span: first > last wraps through the top index, equal gives one beat.
  logic [ADDR_WIDTH-1:0] w_span;
  logic [ADDR_WIDTH-1:0] w_next_index;

  assign w_span       = last_reg - first_reg;
  assign w_next_index = r_index + c_IDX_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_count     <= '0;
      r_hold_req  <= 1'b0;
      r_rd_reg    <= '0;
      r_out_valid <= 1'b0;
      r_out_reg   <= '0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_index    <= first_reg;
            r_count    <= {1'b0, w_span} + c_CNT_ONE;
            r_checksum <= '0;
            r_hold_req <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // The read address is set up on entry so rd_data is valid during READ.
          if (hold_ack) begin
            r_rd_reg <= r_index;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          r_out_data  <= rd_data;
          r_out_reg   <= r_index;
          r_checksum  <= r_checksum + rd_data;
          r_out_valid <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_count == c_CNT_ONE) begin
              r_count    <= '0;
              r_hold_req <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_count  <= r_count - c_CNT_ONE;
              r_index  <= w_next_index;
              r_rd_reg <= w_next_index;
              r_state  <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hold_req  = r_hold_req;
  assign rd_reg    = r_rd_reg;
  assign out_valid = r_out_valid;
  assign out_reg   = r_out_reg;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire
